// File: rtl/debug_trace_rx_if.sv
// Serial input and record-output bundle for debug_trace_rx.
// DEBUG_TRACE_RX_STATS_EN adds the record/error counter signals.
interface debug_trace_rx_if #(
  parameter int CAPTURE_WIDTH_BITS = 88
);
  logic                          uart_rx;
  logic                          record_valid;
  logic [CAPTURE_WIDTH_BITS-1:0] record_data;
  logic                          frame_error;
  logic                          record_dropped;
`ifdef DEBUG_TRACE_RX_STATS_EN
  logic [31:0]                   rx_record_count;
  logic [15:0]                   rx_error_count;

  modport master (
    input  uart_rx,
    output record_valid, record_data, frame_error, record_dropped,
    output rx_record_count, rx_error_count
  );
  modport slave (
    output uart_rx,
    input  record_valid, record_data, frame_error, record_dropped,
    input  rx_record_count, rx_error_count
  );
`else
  modport master (
    input  uart_rx,
    output record_valid, record_data, frame_error, record_dropped
  );
  modport slave (
    output uart_rx,
    input  record_valid, record_data, frame_error, record_dropped
  );
`endif
endinterface

// File: rtl/debug_trace_rx.sv
// 8N1 UART receiver packing LSB-first bytes into records; record_valid pulses 1 cycle after the last stop-bit sample,
// no backpressure (every pulse must be taken). DEBUG_TRACE_RX_STATS_EN adds record/error counters.
module debug_trace_rx #(
  parameter int BAUD_DIVIDE        = 434,
  parameter int CAPTURE_WIDTH_BITS = 88,
  parameter int IDLE_TIMEOUT_BITS  = 20
) (
  input  logic             clk,
  input  logic             reset,
  debug_trace_rx_if.master bus
);
  localparam int BYTES_PER_RECORD = (CAPTURE_WIDTH_BITS + 7) / 8;
  localparam int GAP_LIMIT        = IDLE_TIMEOUT_BITS * BAUD_DIVIDE;
  localparam int BW               = $clog2(BAUD_DIVIDE) + 1;
  localparam int GW               = $clog2(GAP_LIMIT) + 1;
  localparam int IW               = $clog2(BYTES_PER_RECORD) + 1;
  localparam int CW               = CAPTURE_WIDTH_BITS;

  localparam logic [BW-1:0] BAUD_FULL = BW'(BAUD_DIVIDE);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIVIDE / 2);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LIMIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(BYTES_PER_RECORD - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  rx_state_e         state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [BW-1:0]     baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [CW-1:0]     rec_q, rec_d;
  logic [CW-1:0]     rec_full;
  logic [CW-1:0]     data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              drop_q, drop_d;
  logic              baud_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.uart_rx;
      sync2_q <= sync1_q;
    end
  end

  assign baud_done = (baud_q == BW'(1));

  // Record as it would look with the byte in shift_q written into lane idx_q; bits past CW are dropped.
  always_comb begin
    rec_full = rec_q;
    for (int i = 0; i < CW; i++) begin
      if (idx_q == IW'(i / 8)) rec_full[i] = shift_q[i % 8];
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    gap_d   = '0;
    rec_d   = rec_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        // Timeout and a same-cycle start edge both act: the new byte opens a fresh record.
        if (idx_q != '0) begin
          if (gap_q == GAP_LAST) begin
            drop_d = 1'b1;
            idx_d  = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        if (!sync2_q) begin
          state_d = RX_START;
          baud_d  = BAUD_HALF;
        end
      end
      RX_START: begin
        if (baud_done) begin
          if (!sync2_q) begin
            state_d = RX_DATA;
            bit_d   = '0;
            baud_d  = BAUD_FULL;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (baud_done) begin
          shift_d = {sync2_q, shift_q[7:1]};
          baud_d  = BAUD_FULL;
          if (bit_q == 4'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (baud_done) begin
          if (sync2_q) begin
            state_d = RX_IDLE;
            if (idx_q == IDX_LAST) begin
              valid_d = 1'b1;
              data_d  = rec_full;
              idx_d   = '0;
            end else begin
              rec_d = rec_full;
              idx_d = idx_q + 1'b1;
            end
          end else begin
            state_d = RX_BREAK;
            ferr_d  = 1'b1;
            drop_d  = (idx_q != '0);
            idx_d   = '0;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      RX_BREAK: begin
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      rec_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      rec_q   <= rec_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.record_valid   = valid_q;
  assign bus.record_data    = data_q;
  assign bus.frame_error    = ferr_q;
  assign bus.record_dropped = drop_q;

`ifdef DEBUG_TRACE_RX_STATS_EN
  logic [31:0] rec_cnt_q;
  logic [15:0] err_cnt_q;

  // Updated on the same edge that launches the pulses so counts line up with them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (valid_d) rec_cnt_q <= rec_cnt_q + 1'b1;
      if ((ferr_d || drop_d) && (err_cnt_q != 16'hffff)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.rx_record_count = rec_cnt_q;
  assign bus.rx_error_count  = err_cnt_q;
`endif
endmodule

// File: tb/tb_debug_trace_rx.sv
// Bench for debug_trace_rx: vector table, hand-written corner sequences, then random bytes against a byte-queue model.
module tb_debug_trace_rx;
  localparam int BAUD = 8;
  localparam int CW   = 20;
  localparam int TMO  = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  debug_trace_rx_if #(.CAPTURE_WIDTH_BITS(CW)) bus ();

  debug_trace_rx #(
    .BAUD_DIVIDE       (BAUD),
    .CAPTURE_WIDTH_BITS(CW),
    .IDLE_TIMEOUT_BITS (TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] got_q[$];
  int   n_valid = 0, n_fe = 0, n_drop = 0, n_both = 0, n_wide = 0, n_overlap = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.record_valid) begin
        got_q.push_back(bus.record_data);
        n_valid++;
        if (prev_valid) n_wide++;
        if (bus.frame_error || bus.record_dropped) n_overlap++;
      end
      if (bus.frame_error) n_fe++;
      if (bus.record_dropped) n_drop++;
      if (bus.frame_error && bus.record_dropped) n_both++;
    end
    prev_valid = bus.record_valid;
  end

  int rd_idx = 0;
  int b_valid, b_fe, b_drop, b_both;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    rd_idx  = got_q.size();
    b_valid = n_valid;
    b_fe    = n_fe;
    b_drop  = n_drop;
    b_both  = n_both;
  endtask

  task automatic expect_rec(input string name, input logic [CW-1:0] exp);
    if (rd_idx < got_q.size()) begin
      check(name, 64'(got_q[rd_idx]), 64'(exp));
      rd_idx++;
    end else begin
      checks++;
      failures++;
      $display("FAIL %s: no record received, expected %0h", name, exp);
    end
  endtask

  // All line drives start at a negedge and hold for n whole cycles.
  task automatic hold(input logic v, input int n);
    bus.uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    hold(1'b0, BAUD);
    for (int i = 0; i < 8; i++) hold(b[i], BAUD);
    hold(stop_ok, BAUD);
    if (!stop_ok) hold(1'b1, 2 * BAUD);
  endtask

  task automatic send_rec(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
  endtask

  typedef struct {
    logic [7:0]    b0, b1, b2;
    logic [CW-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  logic [7:0]    pend[$];
  logic [CW-1:0] exp_q[$];
  logic [23:0]   w;
  logic [7:0]    rb;
  logic          rok;
  int            exp_fe, exp_drop, exp_err, exp_recs_since_rst;

  initial begin
    vecs[0] = '{8'h5A, 8'hC3, 8'hF7, 20'h7C35A};
    vecs[1] = '{8'h01, 8'h02, 8'h03, 20'h30201};
    vecs[2] = '{8'h10, 8'h20, 8'h30, 20'h02010};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 20'hFFFFF};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 20'h00000};
    vecs[5] = '{8'h12, 8'h34, 8'h56, 20'h63412};

    bus.uart_rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.record_valid, 0);
    check("rst_data", bus.record_data, 0);
    check("rst_ferr", bus.frame_error, 0);
    check("rst_drop", bus.record_dropped, 0);
`ifdef DEBUG_TRACE_RX_STATS_EN
    check("rst_rec_cnt", bus.rx_record_count, 0);
    check("rst_err_cnt", bus.rx_error_count, 0);
`endif
    reset = 1'b0;
    hold(1'b1, 2 * BAUD);

    // Vector table
    snap();
    for (int v = 0; v < 6; v++) begin
      send_rec(vecs[v].b0, vecs[v].b1, vecs[v].b2);
      hold(1'b1, 3 * BAUD);
      expect_rec($sformatf("vec%0d_data", v), vecs[v].exp);
    end
    check("vec_nvalid", n_valid - b_valid, 6);
    check("vec_noerr", (n_fe - b_fe) + (n_drop - b_drop), 0);
    check("data_holds", bus.record_data, 20'h63412);

    // Glitch shorter than half a bit
    snap();
    hold(1'b0, 3);
    hold(1'b1, 6 * BAUD);
    check("glitch_quiet", (n_valid - b_valid) + (n_fe - b_fe) + (n_drop - b_drop), 0);
    send_rec(8'h5A, 8'hC3, 8'hF7);
    hold(1'b1, 3 * BAUD);
    expect_rec("glitch_next", 20'h7C35A);

    // Frame error on the second byte of a record
    snap();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    hold(1'b1, 2 * BAUD);
    check("ferr_count", n_fe - b_fe, 1);
    check("ferr_drop", n_drop - b_drop, 1);
    check("ferr_same_cycle", n_both - b_both, 1);
    check("ferr_no_rec", n_valid - b_valid, 0);
    send_rec(8'h01, 8'h02, 8'h03);
    hold(1'b1, 3 * BAUD);
    expect_rec("ferr_next", 20'h30201);

    // Inter-byte timeout
    snap();
    send_byte(8'hAA, 1'b1);
    hold(1'b1, TMO * BAUD + 1);
    check("tmo_drop", n_drop - b_drop, 1);
    check("tmo_no_ferr", n_fe - b_fe, 0);
    check("tmo_no_rec", n_valid - b_valid, 0);
    send_rec(8'h10, 8'h20, 8'h30);
    hold(1'b1, 3 * BAUD);
    expect_rec("tmo_next", 20'h02010);

    // Two records back to back
    snap();
    send_rec(8'h11, 8'h22, 8'h33);
    send_rec(8'h44, 8'h55, 8'h66);
    hold(1'b1, 3 * BAUD);
    check("b2b_nvalid", n_valid - b_valid, 2);
    expect_rec("b2b_rec0", 20'h32211);
    expect_rec("b2b_rec1", 20'h65544);
    check("b2b_width", n_wide, 0);

    // Reset in the middle of a byte with a partial record pending
    snap();
    send_byte(8'h77, 1'b1);
    hold(1'b0, BAUD);
    for (int i = 0; i < 4; i++) hold(1'b1, BAUD);
    hold(1'b0, BAUD / 2 + 2);
    reset = 1'b1;
    bus.uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_valid", bus.record_valid, 0);
    check("mid_rst_data", bus.record_data, 0);
    check("mid_rst_ferr", bus.frame_error, 0);
    check("mid_rst_drop", bus.record_dropped, 0);
`ifdef DEBUG_TRACE_RX_STATS_EN
    check("mid_rst_rec_cnt", bus.rx_record_count, 0);
    check("mid_rst_err_cnt", bus.rx_error_count, 0);
`endif
    reset = 1'b0;
    hold(1'b1, 2 * BAUD);
    send_rec(8'h12, 8'h34, 8'h56);
    hold(1'b1, 3 * BAUD);
    expect_rec("post_rst_rec", 20'h63412);
    check("post_rst_quiet", (n_fe - b_fe) + (n_drop - b_drop), 0);
    exp_recs_since_rst = 1;

    // Random bytes against the byte-queue model
    snap();
    exp_fe = 0;
    exp_drop = 0;
    exp_err = 0;
    for (int i = 0; i < 61; i++) begin
      if (i < 60) begin
        rb  = 8'($urandom_range(0, 255));
        rok = ($urandom_range(0, 9) != 0);
        send_byte(rb, rok);
        if (rok) begin
          pend.push_back(rb);
          if (pend.size() == 3) begin
            w = {pend[2], pend[1], pend[0]};
            exp_q.push_back(w[CW-1:0]);
            pend.delete();
          end
        end else begin
          exp_fe++;
          exp_err++;
          if (pend.size() != 0) exp_drop++;
          pend.delete();
        end
      end
      if (i == 60 || $urandom_range(0, 7) == 0) begin
        hold(1'b1, TMO * BAUD + 40);
        if (pend.size() != 0) begin
          exp_drop++;
          exp_err++;
          pend.delete();
        end
      end else begin
        hold(1'b1, $urandom_range(0, 3 * BAUD));
      end
    end
    check("rand_nvalid", n_valid - b_valid, exp_q.size());
    foreach (exp_q[k]) expect_rec($sformatf("rand_rec%0d", k), exp_q[k]);
    check("rand_ferr", n_fe - b_fe, exp_fe);
    check("rand_drop", n_drop - b_drop, exp_drop);
`ifdef DEBUG_TRACE_RX_STATS_EN
    check("stats_rec_cnt", bus.rx_record_count, exp_recs_since_rst + exp_q.size());
    check("stats_err_cnt", bus.rx_error_count, exp_err);
`endif
    check("valid_width", n_wide, 0);
    check("valid_overlap", n_overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
